// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i-pico core: datapath width, fetch FSM
// states, and the base opcode encodings that both fetch and decode rely on.
package rv32i_pkg;

   localparam int XLEN = 32;

   // Canonical no-op (addi x0, x0, 0), used wherever a bubble is needed.
   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

   // Base RV32I major opcodes (instr[6:0]).
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // Fetch FSM: issue a request, wait for its data, hold it for decode.
   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_HOLD = 2'd2
   } fetch_state_t;

   // Force an address onto a word boundary by clearing the byte offset.
   function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time on the
// req/gnt/rvalid memory interface, buffers the returned word in a one-entry
// buffer and hands it to decode over valid/ready. A redirect from execute
// cancels whatever is in flight and restarts fetch at the new target.
module fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            mem_req_o,
   output logic [XLEN-1:0] mem_addr_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   output logic [6:0]      opcode_o,
   output logic [2:0]      func3_o,
   output logic            fetch_err_o
);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_kill;
   logic [XLEN-1:0] r_ibuf;
   logic [XLEN-1:0] r_ibufPc;
   logic            r_instrValid;
   logic            r_fetchErr;

   logic [XLEN-1:0] w_redirectPc;
   logic            w_misaligned;

   assign w_redirectPc = wordAlign(redirect_pc_i);
   assign w_misaligned = (redirect_pc_i[1:0] != 2'b00);

   // A request is only ever presented from REQ, so at most one is outstanding.
   assign mem_req_o     = (r_state == FETCH_REQ);
   assign mem_addr_o    = r_pc;

   assign instr_valid_o = r_instrValid;
   assign instr_o       = r_ibuf;
   assign instr_pc_o    = r_ibufPc;
   assign opcode_o      = r_ibuf[6:0];
   assign func3_o       = r_ibuf[14:12];
   assign fetch_err_o   = r_fetchErr;

   // Fetch FSM with the PC, kill flag and one-entry instruction buffer; a
   // redirect overrides every other event in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= FETCH_REQ;
         r_pc         <= RESET_PC;
         r_kill       <= 1'b0;
         r_ibuf       <= '0;
         r_ibufPc     <= '0;
         r_instrValid <= 1'b0;
         r_fetchErr   <= 1'b0;
      end else begin
         r_fetchErr <= redirect_i && w_misaligned;

         if (redirect_i) begin
            r_pc <= w_redirectPc;
            case (r_state)
               FETCH_REQ: begin
                  // A request granted this same cycle is already in flight;
                  // its response must be swallowed.
                  if (mem_gnt_i) begin
                     r_state <= FETCH_WAIT;
                     r_kill  <= 1'b1;
                  end
               end
               FETCH_WAIT: begin
                  if (mem_rvalid_i) begin
                     r_state <= FETCH_REQ;
                     r_kill  <= 1'b0;
                  end else begin
                     r_kill  <= 1'b1;
                  end
               end
               FETCH_HOLD: begin
                  r_state      <= FETCH_REQ;
                  r_instrValid <= 1'b0;
               end
               default: begin
                  r_state <= FETCH_REQ;
               end
            endcase
         end else begin
            case (r_state)
               FETCH_REQ: begin
                  if (mem_gnt_i) begin
                     r_ibufPc <= r_pc;
                     r_pc     <= r_pc + 32'd4;
                     r_state  <= FETCH_WAIT;
                  end
               end
               FETCH_WAIT: begin
                  if (mem_rvalid_i) begin
                     if (r_kill) begin
                        r_kill  <= 1'b0;
                        r_state <= FETCH_REQ;
                     end else begin
                        r_ibuf       <= mem_rdata_i;
                        r_instrValid <= 1'b1;
                        r_state      <= FETCH_HOLD;
                     end
                  end
               end
               FETCH_HOLD: begin
                  if (instr_ready_i) begin
                     r_instrValid <= 1'b0;
                     r_state      <= FETCH_REQ;
                  end
               end
               default: begin
                  r_state <= FETCH_REQ;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the rv32i-pico core. Holds the program counter and issues one 32-bit read at a time on the instruction-memory request/grant/response interface. Buffers the returned word and presents it, with its PC and pre-split `opcode`/`func3` fields, to the decode controller over a valid/ready handshake. Redirects from execute (branch/jump) cancel in-flight work and restart fetch at the new PC.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset; must be 4-byte aligned.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `redirect_i`  in  1  one-cycle pulse; restart fetch at `redirect_pc_i`.
- `redirect_pc_i`  in  32  redirect target.
- `mem_req_o`  out  1  read request valid.
- `mem_addr_o`  out  32  read address; always word aligned.
- `mem_gnt_i`  in  1  memory accepted request this cycle.
- `mem_rvalid_i`  in  1  read data valid.
- `mem_rdata_i`  in  32  read data.
- `instr_valid_o`  out  1  `instr_o` holds a valid instruction.
- `instr_ready_i`  in  1  decode consumes the instruction this cycle.
- `instr_o`  out  32  buffered instruction word.
- `instr_pc_o`  out  32  PC of `instr_o`.
- `opcode_o`  out  7  `instr_o[6:0]`.
- `func3_o`  out  3  `instr_o[14:12]`.
- `fetch_err_o`  out  1  one-cycle pulse on a misaligned redirect target.

## Operation

- State register `state` ∈ {REQ, WAIT, HOLD}; reset value REQ.
- Internal registers:
  - `pc`: next fetch address; reset `RESET_PC`.
  - `kill`: discard the next response; reset 0.
  - `ibuf`, `ibuf_pc`: reset 0.
- Output reset values: `instr_valid_o`=0, `instr_o`=0, `instr_pc_o`=0, `fetch_err_o`=0.
- `mem_req_o`=1 exactly when `state`==REQ. `mem_addr_o`=`pc`.

Transitions (`redirect_i` has priority over every other event):
- REQ:
  - `mem_gnt_i`: capture `ibuf_pc`←`pc`, `pc`←`pc`+4, go WAIT.
  - No grant: stay in REQ.
- WAIT:
  - `mem_rvalid_i` and !`kill`: `ibuf`←`mem_rdata_i`, go HOLD.
  - `mem_rvalid_i` and `kill`: drop the data, clear `kill`, go REQ.
- HOLD:
  - `instr_valid_o`=1.
  - `instr_ready_i`: go REQ.

Redirect handling:
- Always: `pc`←{`redirect_pc_i`[31:2], 2'b00}.
- If `redirect_pc_i`[1:0]≠0: pulse `fetch_err_o` the next cycle.
- REQ, no grant: stay in REQ; the address changes next cycle. Withdrawing or retargeting an ungranted request is legal on this interface.
- REQ with `mem_gnt_i` in the same cycle: the request is already accepted. Go WAIT with `kill`←1; `pc` still takes the redirect target, not +4.
- WAIT: `kill`←1 and stay in WAIT. If `mem_rvalid_i` arrives the same cycle, that response is dropped and the FSM goes to REQ with `kill`=0.
- HOLD: drop the buffered instruction (`instr_valid_o`←0) and go REQ, even if `instr_ready_i` is high.

Other rules:
- At most one outstanding memory request.
- `mem_rvalid_i` outside WAIT is a protocol error; ignore it.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- `opcode_o` and `func3_o` are pure slices of `instr_o`, with no decoding. Illegal opcodes are reported downstream, not here.

## Timing

- Cycle after `rst_n` rises: `mem_req_o`=1, `mem_addr_o`=`RESET_PC`.
- Memory with grant in the request cycle and rvalid one cycle later:
  - First `instr_valid_o` appears 2 cycles after the first request cycle.
  - Steady-state throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) when `instr_ready_i` is held high.
- `instr_o`, `instr_pc_o` and `instr_valid_o` are registered and stable while `instr_valid_o`=1 and `instr_ready_i`=0.
- Redirect to first request at the target: 1 cycle from REQ or HOLD. From WAIT: 1 cycle after the killed response returns.
- Reset asserted mid-transaction returns every register to its reset value immediately. A response arriving after reset is released is ignored, because state is REQ.

## Structure

- Shared package `rv32i_pkg`:
  - `fetch_state_t` enum.
  - `XLEN`=32 constant.
  - `INSTR_NOP`=32'h0000_0013.
  - Opcode constants (`OPC_OP_IMM`=7'b0010011, and the others), so that decode and fetch use identical encodings.
- Single module; no sub-module. The one-entry buffer and the FSM are kept inline.

## Test plan

- Reset, `RESET_PC`=0, memory always grants with rvalid next cycle returning 32'h00500093 (addi x1,x0,5). Required:
  - Addresses 0, 4, 8 in order.
  - `opcode_o`=7'b0010011, `func3_o`=3'b000.
  - `instr_pc_o`=0, 4, 8.
- Backpressure: `instr_ready_i`=0 for 5 cycles while `instr_valid_o`=1.
  - `instr_o` and `instr_pc_o` stay unchanged; `mem_req_o` stays 0.
  - After ready rises, the next request goes to the next PC.
- Grant delay: `mem_gnt_i` held low 3 cycles. `mem_req_o` and `mem_addr_o` stay stable; `pc` increments only once.
- Redirect in WAIT to 32'h100, with rvalid the next cycle returning 32'hDEADBEEF. That word is never presented; the next request address is 32'h100.
- Redirect coincident with grant, then redirect during HOLD:
  - Next valid instruction has `instr_pc_o`=target.
  - Redirect to 32'h102 pulses `fetch_err_o` once and fetches 32'h100.
- Wrap-around: `RESET_PC`=32'hFFFF_FFFC. The second request address is 32'h0000_0000.
